ir_cmd_scheduler: RTL and testbench

Sequences decoded IR frames into the channel controller. Sits between the NEC frame decoder and `channel_ctrl`. Buffers new-frame commands in a small FIFO and converts held-key repeat frames into auto-repeat CH+/CH- commands. Issues commands to `channel_ctrl` as rate-limited single-cycle `out_valid` pulses.

---
 rtl/ir_cmd_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_ir_cmd_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_cmd_scheduler.sv
// ir_cmd_scheduler
//   Queues decoded IR frames for channel_ctrl and turns held-key NEC repeat
//   frames into auto-repeat CH+/CH- commands. Commands leave as rate-limited
//   single-cycle pulses.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_cmd        command byte of a new frame, qualified by in_valid
//   in_valid      one-cycle pulse: new frame decoded
//   in_repeat     one-cycle pulse: NEC repeat frame decoded
//   flush         synchronous clear of FIFO, hold state and issue FSM
//   out_cmd       command to channel_ctrl, held while out_valid is low
//   out_valid     one-cycle issue pulse
//   fifo_level    FIFO occupancy (registered)
//   fifo_full     fifo_level == FIFO_DEPTH
//   drop_cnt      frames lost to overflow, saturating at 255
module ir_cmd_scheduler #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned HOLD_REPEATS = 2,
    parameter int unsigned TIMEOUT      = 1000,
    parameter int unsigned MIN_GAP      = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_cmd,
    input  logic                          in_valid,
    input  logic                          in_repeat,
    input  logic                          flush,
    output logic [7:0]                    out_cmd,
    output logic                          out_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_full,
    output logic [7:0]                    drop_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = (HOLD_REPEATS > 0) ? $clog2(HOLD_REPEATS + 1) : 1;
    localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    localparam logic [LW-1:0] DepthL   = LW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TimeoutL = TW'(TIMEOUT);
    localparam logic [RW-1:0] HoldL    = RW'(HOLD_REPEATS);
    localparam logic [GW-1:0] GapInit  = GW'(MIN_GAP - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [7:0]    last_cmd_q, last_cmd_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          hold_q, hold_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    state_e        state_q, state_d;
    logic [7:0]    out_cmd_q, out_cmd_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    drop_q, drop_d;

    logic          push_req, push_ok, pop, repeatable;
    logic [7:0]    push_data;

    assign repeatable = (last_cmd_q == 8'h18) || (last_cmd_q == 8'h38);

    always_comb begin
        push_req    = 1'b0;
        push_data   = in_cmd;
        last_cmd_d  = last_cmd_q;
        rep_cnt_d   = rep_cnt_q;
        hold_d      = hold_q;
        to_cnt_d    = to_cnt_q;
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        out_cmd_d   = out_cmd_q;
        out_valid_d = 1'b0;
        pop         = 1'b0;

        // Frame intake and hold tracking; a new frame outranks a repeat.
        if (in_valid) begin
            push_req   = 1'b1;
            last_cmd_d = in_cmd;
            rep_cnt_d  = '0;
            hold_d     = 1'b1;
            to_cnt_d   = TimeoutL;
        end else if (in_repeat && hold_q && repeatable) begin
            to_cnt_d = TimeoutL;
            if (rep_cnt_q < HoldL) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end else begin
                push_req  = 1'b1;
                push_data = last_cmd_q;
            end
        end else if (hold_q) begin
            if (to_cnt_q == '0) begin
                hold_d = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q - 1'b1;
            end
        end

        // Issue FSM. The last gap cycle may issue directly so the pulse period
        // is exactly MIN_GAP+1 while the FIFO stays non-empty.
        unique case (state_q)
            StIssue: begin
                gap_cnt_d = GapInit;
                state_d   = StGap;
            end
            StIdle, StGap: begin
                if (state_q == StGap && gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end else if (cnt_q != '0) begin
                    pop         = 1'b1;
                    out_cmd_d   = mem_q[rd_ptr_q];
                    out_valid_d = 1'b1;
                    state_d     = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush discards any same-cycle frame without counting it as a drop.
        if (flush) begin
            push_req    = 1'b0;
            pop         = 1'b0;
            last_cmd_d  = last_cmd_q;
            rep_cnt_d   = '0;
            hold_d      = 1'b0;
            to_cnt_d    = '0;
            state_d     = StIdle;
            gap_cnt_d   = '0;
            out_cmd_d   = out_cmd_q;
            out_valid_d = 1'b0;
        end
    end

    assign push_ok = push_req && ((cnt_q < DepthL) || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + LW'(push_ok) - LW'(pop);
        drop_d   = drop_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_req && !push_ok && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            last_cmd_q  <= '0;
            rep_cnt_q   <= '0;
            hold_q      <= 1'b0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            state_q     <= StIdle;
            out_cmd_q   <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            last_cmd_q  <= last_cmd_d;
            rep_cnt_q   <= rep_cnt_d;
            hold_q      <= hold_d;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            state_q     <= state_d;
            out_cmd_q   <= out_cmd_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign out_cmd    = out_cmd_q;
    assign out_valid  = out_valid_q;
    assign fifo_level = cnt_q;
    assign fifo_full  = (cnt_q == DepthL);
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// tb_ir_cmd_scheduler
//   Directed bench for ir_cmd_scheduler. Expected commands are queued as
//   frames are driven and consumed by a monitor on each out_valid pulse.
module tb_ir_cmd_scheduler;

    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned HOLD_REPEATS = 2;
    localparam int unsigned TIMEOUT      = 1000;
    localparam int unsigned MIN_GAP      = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_cmd;
    logic       in_valid, in_repeat, flush;
    logic [7:0] out_cmd;
    logic       out_valid;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic       fifo_full;
    logic [7:0] drop_cnt;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         pulses[$];

    ir_cmd_scheduler #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_REPEATS(HOLD_REPEATS),
        .TIMEOUT     (TIMEOUT),
        .MIN_GAP     (MIN_GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_cmd    (in_cmd),
        .in_valid  (in_valid),
        .in_repeat (in_repeat),
        .flush     (flush),
        .out_cmd   (out_cmd),
        .out_valid (out_valid),
        .fifo_level(fifo_level),
        .fifo_full (fifo_full),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard compare and minimum pulse spacing.
    initial begin
        int last_pulse = -100;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                check("pulse_spacing", 32'((cyc - last_pulse) >= int'(MIN_GAP + 1)), 32'd1);
                last_pulse = cyc;
                pulses.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_pulse: got cmd %0h at cycle %0d expected no pulse",
                           out_cmd, cyc);
                end else begin
                    check("out_cmd", 32'(out_cmd), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] c);
        in_cmd   = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_rep();
        in_repeat = 1'b1;
        tick();
        in_repeat = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        idle(MIN_GAP + 3);
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        in_cmd    = 8'h00;
        in_valid  = 1'b0;
        in_repeat = 1'b0;
        flush     = 1'b0;
        idle(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_cmd", 32'(out_cmd), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Single POWER frame: pulse exactly one edge after the write.
        pulses.delete();
        exp_q.push_back(8'h80);
        send_frame(8'h80);
        k = cyc;
        check("single_level_after_push", 32'(fifo_level), 32'd1);
        tick();
        check("single_valid_hi", 32'(out_valid), 32'd1);
        check("single_cmd", 32'(out_cmd), 32'h80);
        check("single_level_after_pop", 32'(fifo_level), 32'd0);
        tick();
        check("single_valid_lo", 32'(out_valid), 32'd0);
        check("single_cmd_hold", 32'(out_cmd), 32'h80);
        drain("single");
        check("single_pulse_count", 32'(pulses.size()), 32'd1);
        if (pulses.size() == 1) check("single_pulse_cycle", 32'(pulses[0]), 32'(k + 1));

        // Four back-to-back frames: period MIN_GAP+1.
        pulses.delete();
        exp_q.push_back(8'h18);
        send_frame(8'h18);
        k = cyc;
        exp_q.push_back(8'h38);
        send_frame(8'h38);
        exp_q.push_back(8'h18);
        send_frame(8'h18);
        exp_q.push_back(8'h80);
        send_frame(8'h80);
        drain("b2b");
        check("b2b_pulse_count", 32'(pulses.size()), 32'd4);
        if (pulses.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("b2b_pulse_cycle", 32'(pulses[i]), 32'(k + 1 + 4 * i));
            end
        end
        check("b2b_drop_cnt", 32'(drop_cnt), 32'd0);

        // Overflow while draining: one prior frame, then six frames; the sixth drops.
        pulses.delete();
        exp_q.push_back(8'h01);
        send_frame(8'h01);
        tick();
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            send_frame(8'(8'h10 + i));
        end
        check("ovf_fifo_full", 32'(fifo_full), 32'd1);
        check("ovf_fifo_level", 32'(fifo_level), 32'd4);
        send_frame(8'h16);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
        drain("ovf");
        check("ovf_pulse_count", 32'(pulses.size()), 32'd6);
        check("ovf_level_empty", 32'(fifo_level), 32'd0);

        // Held CH+: two repeats absorbed, the next three auto-repeat.
        pulses.delete();
        exp_q.push_back(8'h18);
        send_frame(8'h18);
        for (int r = 1; r <= 5; r++) begin
            idle(99);
            if (r > HOLD_REPEATS) exp_q.push_back(8'h18);
            send_rep();
        end
        drain("chup_hold");
        check("chup_pulse_count", 32'(pulses.size()), 32'd4);

        // POWER is not repeatable.
        pulses.delete();
        exp_q.push_back(8'h80);
        send_frame(8'h80);
        for (int r = 0; r < 4; r++) begin
            idle(9);
            send_rep();
        end
        drain("power_rep");
        check("power_pulse_count", 32'(pulses.size()), 32'd1);

        // Hold expiry: repeats well past TIMEOUT are ignored.
        pulses.delete();
        exp_q.push_back(8'h38);
        send_frame(8'h38);
        idle(1049);
        send_rep();
        send_rep();
        send_rep();
        drain("expired");
        check("expired_pulse_count", 32'(pulses.size()), 32'd1);

        // Repeat at 999 cycles still counts: two more repeats then an auto-repeat.
        pulses.delete();
        exp_q.push_back(8'h38);
        send_frame(8'h38);
        idle(998);
        send_rep();
        send_rep();
        exp_q.push_back(8'h38);
        send_rep();
        drain("in_time");
        check("in_time_pulse_count", 32'(pulses.size()), 32'd2);

        // Flush with three queued and a simultaneous frame.
        pulses.delete();
        exp_q.push_back(8'h21);
        send_frame(8'h21);
        send_frame(8'h22);
        send_frame(8'h23);
        send_frame(8'h24);
        check("flush_level_before", 32'(fifo_level), 32'd3);
        in_cmd   = 8'h25;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_level_after", 32'(fifo_level), 32'd0);
        check("flush_full_after", 32'(fifo_full), 32'd0);
        check("flush_drop_cnt", 32'(drop_cnt), 32'd1);
        idle(40);
        check("flush_pulse_count", 32'(pulses.size()), 32'd1);
        check("flush_sb_empty", 32'(exp_q.size()), 32'd0);

        // FSM is idle right after flush: next frame issues one edge later.
        pulses.delete();
        exp_q.push_back(8'h26);
        send_frame(8'h26);
        k = cyc;
        drain("post_flush");
        check("post_flush_count", 32'(pulses.size()), 32'd1);
        if (pulses.size() == 1) check("post_flush_cycle", 32'(pulses[0]), 32'(k + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
